// File: rtl/jtag_ir_dr_chain.sv
// jtag_ir_dr_chain: JTAG instruction register and BYPASS/IDCODE/USER data-register scan chains.
// Optional macro JTAG_IDCODE_EN adds the IDCODE data register and makes Test-Logic-Reset select IDCODE.
module jtag_ir_dr_chain #(
    parameter int              IR_W       = 4,
    parameter int              DR_W       = 32,
    parameter logic [31:0]     IDCODE_VAL = 32'h1BA0_1477,
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'h1),
    parameter logic [IR_W-1:0] OP_USER    = IR_W'(4'h8),
    parameter logic [IR_W-1:0] OP_BYPASS  = {IR_W{1'b1}}
) (
    input  logic            TCK,
    input  logic            TLR,
    input  logic            TDI,
    input  logic            CAPTUREIR,
    input  logic            SHIFTIR,
    input  logic            UPDATEIR,
    input  logic            CAPTUREDR,
    input  logic            SHIFTDR,
    input  logic            UPDATEDR,
    output logic            TDO,
    output logic            TDO_EN,
    output logic [IR_W-1:0] ir_out,
    input  logic [DR_W-1:0] user_in,
    output logic [DR_W-1:0] user_out,
    output logic            user_update
);
`ifdef JTAG_IDCODE_EN
    localparam bit HAS_IDCODE = 1'b1;
`else
    localparam bit HAS_IDCODE = 1'b0;
`endif
    localparam logic [IR_W-1:0] IR_RST = HAS_IDCODE ? OP_IDCODE : OP_BYPASS;

    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb
        $error("IDCODE_VAL bit 0 must be 1");
    end
    if (IR_W < 2) begin : g_ir_w
        $error("IR_W must be at least 2");
    end

    logic [IR_W-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
    logic [DR_W-1:0] dr_q, dr_d, user_out_q, user_out_d;
    logic            bypass_q, bypass_d, user_update_q, user_update_d;
    logic            is_user, is_idcode, is_bypass;

    // Every opcode other than USER (and IDCODE when built in) selects BYPASS.
    assign is_user   = ir_q == OP_USER;
    assign is_idcode = HAS_IDCODE && ir_q == OP_IDCODE;
    assign is_bypass = !is_user && !is_idcode;

    always_comb begin
        ir_shift_d    = ir_shift_q;
        ir_d          = ir_q;
        bypass_d      = bypass_q;
        dr_d          = dr_q;
        user_out_d    = user_out_q;
        user_update_d = 1'b0;
        if (CAPTUREIR) ir_shift_d = IR_W'(2'b01);
        else if (SHIFTIR) ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};
        else if (UPDATEIR) ir_d = ir_shift_q;
        else if (CAPTUREDR) begin
            if (is_user) dr_d = user_in;
            else if (is_idcode) dr_d = DR_W'(IDCODE_VAL);
            else bypass_d = 1'b0;
        end else if (SHIFTDR) begin
            if (is_bypass) bypass_d = TDI;
            else dr_d = {TDI, dr_q[DR_W-1:1]};
        end else if (UPDATEDR && is_user) begin
            user_out_d    = dr_q;
            user_update_d = 1'b1;
        end
    end

    always_ff @(posedge TCK) begin
        if (TLR) begin
            ir_q          <= IR_RST;
            ir_shift_q    <= '0;
            bypass_q      <= 1'b0;
            dr_q          <= '0;
            user_out_q    <= '0;
            user_update_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            ir_shift_q    <= ir_shift_d;
            bypass_q      <= bypass_d;
            dr_q          <= dr_d;
            user_out_q    <= user_out_d;
            user_update_q <= user_update_d;
        end
    end

    assign TDO         = SHIFTIR ? ir_shift_q[0] : SHIFTDR ? (is_bypass ? bypass_q : dr_q[0]) : 1'b0;
    assign TDO_EN      = SHIFTIR | SHIFTDR;
    assign ir_out      = ir_q;
    assign user_out    = user_out_q;
    assign user_update = user_update_q;
endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// tb_jtag_ir_dr_chain: directed scans through the IR/DR chains with hand-computed expectations.
module tb_jtag_ir_dr_chain;
    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_TLR  = 7'b1000000;
    localparam logic [6:0] S_CIR  = 7'b0100000;
    localparam logic [6:0] S_SIR  = 7'b0010000;
    localparam logic [6:0] S_UIR  = 7'b0001000;
    localparam logic [6:0] S_CDR  = 7'b0000100;
    localparam logic [6:0] S_SDR  = 7'b0000010;
    localparam logic [6:0] S_UDR  = 7'b0000001;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'h1;
`else
    localparam logic [3:0] RST_IR = 4'hF;
`endif

    logic        TCK = 1'b0, TLR = 1'b0, TDI = 1'b0;
    logic        CAPTUREIR = 1'b0, SHIFTIR = 1'b0, UPDATEIR = 1'b0;
    logic        CAPTUREDR = 1'b0, SHIFTDR = 1'b0, UPDATEDR = 1'b0;
    logic        TDO, TDO_EN, user_update;
    logic [3:0]  ir_out;
    logic [31:0] user_in = '0, user_out;
    logic [63:0] out;
    int          asserts = 0, failures = 0, pulses = 0;

    jtag_ir_dr_chain dut (
        .TCK(TCK), .TLR(TLR), .TDI(TDI),
        .CAPTUREIR(CAPTUREIR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .TDO(TDO), .TDO_EN(TDO_EN), .ir_out(ir_out),
        .user_in(user_in), .user_out(user_out), .user_update(user_update)
    );

    always #5 TCK = ~TCK;
    always @(negedge TCK) if (user_update === 1'b1) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobes change on the falling edge; outputs are sampled 1ns later, before the next rising edge.
    task automatic step(input logic [6:0] s, input logic tdi);
        @(negedge TCK);
        {TLR, CAPTUREIR, SHIFTIR, UPDATEIR, CAPTUREDR, SHIFTDR, UPDATEDR} = s;
        TDI = tdi;
        #1;
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            step(S_SDR, din[i]);
            dout[i] = TDO;
        end
    endtask

    task automatic ir_load(input logic [3:0] op);
        step(S_CIR, 1'b0);
        for (int i = 0; i < 4; i++) step(S_SIR, op[i]);
        step(S_UIR, 1'b0);
        step(S_IDLE, 1'b0);
    endtask

    initial begin
        step(S_TLR, 1'b0);
        step(S_IDLE, 1'b0);
        check("rst_ir", 64'(ir_out), 64'(RST_IR));
        check("rst_user_out", 64'(user_out), 64'h0);
        check("rst_user_update", 64'(user_update), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        check("rst_tdo_en", 64'(TDO_EN), 64'h0);
        step(S_CDR, 1'b0);
`ifdef JTAG_IDCODE_EN
        shift_dr(32, 64'h0, out);
        check("idcode_scan", out, 64'h1BA0_1477);
`else
        shift_dr(4, 64'b1101, out);
        check("reset_bypass_scan", out, 64'b1010);
`endif
        step(S_CIR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(S_SIR, 1'b1);
            out[i] = TDO;
        end
        check("ir_capture_out", 64'(out[3:0]), 64'b0001);
        check("ir_shift_tdo_en", 64'(TDO_EN), 64'h1);
        step(S_UIR, 1'b0);
        step(S_IDLE, 1'b0);
        check("ir_bypass", 64'(ir_out), 64'hF);
        check("idle_tdo_en", 64'(TDO_EN), 64'h0);
        step(S_CDR, 1'b0);
        shift_dr(4, 64'b1101, out);
        check("bypass_scan", out, 64'b1010);
        step(S_UDR, 1'b0);
        step(S_IDLE, 1'b0);
        check("bypass_user_out", 64'(user_out), 64'h0);
        check("bypass_no_update", 64'(user_update), 64'h0);
        ir_load(4'h8);
        check("ir_user", 64'(ir_out), 64'h8);
        user_in = 32'hDEAD_BEEF;
        step(S_CDR, 1'b0);
        shift_dr(32, 64'hCAFE_F00D, out);
        check("user_capture_out", out, 64'hDEAD_BEEF);
        step(S_UDR, 1'b0);
        check("user_update_pre", 64'(user_update), 64'h0);
        step(S_IDLE, 1'b0);
        check("user_update_pulse", 64'(user_update), 64'h1);
        check("user_out_full", 64'(user_out), 64'hCAFE_F00D);
        step(S_IDLE, 1'b0);
        check("user_update_drop", 64'(user_update), 64'h0);
        check("pulse_count_1", 64'(pulses), 64'd1);
        step(S_CDR, 1'b0);
        shift_dr(8, 64'hA5, out);
        check("undershift_out", out, 64'hEF);
        step(S_UDR, 1'b0);
        step(S_IDLE, 1'b0);
        check("undershift_user_out", 64'(user_out), 64'hA5DE_ADBE);
        user_in = 32'h1234_5678;
        step(S_CDR, 1'b0);
        shift_dr(40, 64'h5A_CAFE_F00D, out);
        check("overshift_out", out, 64'h0D_1234_5678);
        step(S_UDR, 1'b0);
        step(S_IDLE, 1'b0);
        check("overshift_user_out", 64'(user_out), 64'h5ACA_FEF0);
        check("pulse_count_3", 64'(pulses), 64'd3);
        step(S_CDR, 1'b0);
        shift_dr(10, 64'h3FF, out);
        step(S_TLR, 1'b0);
        step(S_IDLE, 1'b0);
        check("abort_ir", 64'(ir_out), 64'(RST_IR));
        check("abort_user_out", 64'(user_out), 64'h0);
        check("abort_user_update", 64'(user_update), 64'h0);
        step(S_UDR, 1'b0);
        step(S_IDLE, 1'b0);
        check("abort_post_udr_user_out", 64'(user_out), 64'h0);
        check("abort_pulse_count", 64'(pulses), 64'd3);
        ir_load(4'h5);
        check("ir_undefined", 64'(ir_out), 64'h5);
        step(S_CDR, 1'b0);
        shift_dr(4, 64'b1011, out);
        check("undefined_bypass_scan", out, 64'b0110);
        ir_load(4'h1);
        check("ir_idcode_op", 64'(ir_out), 64'h1);
        step(S_CDR, 1'b0);
`ifdef JTAG_IDCODE_EN
        shift_dr(32, 64'h0, out);
        check("op1_idcode_scan", out, 64'h1BA0_1477);
`else
        shift_dr(4, 64'b1011, out);
        check("op1_bypass_scan", out, 64'b0110);
`endif
        step(S_IDLE, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
